// File: rtl/median_window_feeder.sv
// median_window_feeder
//   Turns a raster pixel stream into 3x3 windows for an external median
//   filter. Two line buffers hold the previous two lines. Every accepted
//   pixel shifts a new column into the window. Once a full window exists
//   (row >= 2, col >= 2), its nine pixels go out row-major on MDI/MDSI. The
//   block then waits for the filter's MDSO and registers the result on
//   RES/RES_VLD. If MDSO does not arrive within TMO cycles, ERR is set and
//   stays set.
//
// Ports
//   CLK      system clock, rising edge
//   nRST     asynchronous active-low reset
//   PIX_I    raster pixel data           PIX_VLD  PIX_I valid
//   SOF      start of frame (with PIX_VLD)
//   PIX_RDY  pixel accepted when PIX_VLD && PIX_RDY
//   MDI      window pixel to filter      MDSI     MDI valid strobe
//   MDO      filter result               MDSO     filter result valid
//   RES      registered median result    RES_VLD  one-cycle "RES is new"
//   ERR      sticky timeout flag
module median_window_feeder #(
    parameter int W   = 8,
    parameter int LW  = 16,
    parameter int TMO = 255
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic [W-1:0] PIX_I,
    input  logic         PIX_VLD,
    input  logic         SOF,
    output logic         PIX_RDY,
    output logic [W-1:0] MDI,
    output logic         MDSI,
    input  logic [W-1:0] MDO,
    input  logic         MDSO,
    output logic [W-1:0] RES,
    output logic         RES_VLD,
    output logic         ERR
);
    localparam int CW = $clog2(LW);

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t        state_reg;
    logic [CW-1:0] col_reg, col_cur, col_next;
    logic [1:0]    row_reg, row_cur, row_next;
    logic [3:0]    k_reg;
    logic [7:0]    wcnt_reg;
    logic          pix_rdy_reg, mdsi_reg, res_vld_reg, err_reg;
    logic [W-1:0]  mdi_reg, res_reg;

    logic [W-1:0]  lb0_mem [LW];
    logic [W-1:0]  lb1_mem [LW];
    logic [W-1:0]  lb0_rd_reg, lb1_rd_reg;
    logic [W-1:0]  win_reg  [9];
    logic [W-1:0]  win_next [9];
    logic [W-1:0]  new_col  [3];

    logic          accept, win_done;

    // PIX_RDY is only ever high in IDLE, so this also implies state IDLE.
    assign accept   = PIX_VLD && pix_rdy_reg;

    // SOF makes the current pixel col 0 / row 0 regardless of position.
    assign col_cur  = SOF ? '0 : col_reg;
    assign row_cur  = SOF ? 2'd0 : row_reg;

    // row saturates at 2, so row_cur == 2 means "third line or later".
    assign win_done = accept && (row_cur == 2'd2) && (col_cur >= CW'(2));

    always_comb begin
        col_next = col_reg;
        row_next = row_reg;
        if (accept) begin
            if (col_cur == CW'(LW - 1)) begin
                col_next = '0;
                row_next = (row_cur == 2'd2) ? 2'd2 : row_cur + 2'd1;
            end else begin
                col_next = col_cur + CW'(1);
                row_next = row_cur;
            end
        end
    end

    // The new right column, top to bottom: two lines ago, last line, now.
    assign new_col[0] = lb1_rd_reg;
    assign new_col[1] = lb0_rd_reg;
    assign new_col[2] = PIX_I;

    // Window is row-major: w[3r+0] is the left pixel and w[3r+2] the right pixel.
    // On SOF, the older two columns restart from zero.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_win_row
            assign win_next[3*gi]   = SOF ? '0 : win_reg[3*gi+1];
            assign win_next[3*gi+1] = SOF ? '0 : win_reg[3*gi+2];
            assign win_next[3*gi+2] = new_col[gi];
        end
        for (gi = 0; gi < 9; gi++) begin : g_win_reg
            always_ff @(posedge CLK) begin
                if (accept) begin
                    win_reg[gi] <= win_next[gi];
                end
            end
        end
    endgenerate

    // Line buffers are block RAM with a registered read. The read address is
    // the column of the next pixel, so the data is ready when that pixel
    // arrives. The write on acceptance always targets a different column
    // than the prefetch. After SOF, the prefetch came from the old column and
    // is wrong for column 0. That only pollutes line-0 data, which is never
    // part of an emitted window.
    always_ff @(posedge CLK) begin
        if (accept) begin
            lb0_mem[col_cur] <= PIX_I;
            lb1_mem[col_cur] <= lb0_rd_reg;
        end
        lb0_rd_reg <= lb0_mem[col_next];
        lb1_rd_reg <= lb1_mem[col_next];
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg   <= IDLE;
            pix_rdy_reg <= 1'b0;
            mdsi_reg    <= 1'b0;
            mdi_reg     <= '0;
            res_reg     <= '0;
            res_vld_reg <= 1'b0;
            err_reg     <= 1'b0;
            col_reg     <= '0;
            row_reg     <= '0;
            wcnt_reg    <= '0;
            k_reg       <= '0;
        end else begin
            res_vld_reg <= 1'b0;
            col_reg     <= col_next;
            row_reg     <= row_next;
            case (state_reg)
                IDLE: begin
                    pix_rdy_reg <= 1'b1;
                    if (win_done) begin
                        // Present w[0] right away so MDSI rises the cycle
                        // after the completing pixel.
                        state_reg   <= SEND;
                        pix_rdy_reg <= 1'b0;
                        mdsi_reg    <= 1'b1;
                        mdi_reg     <= win_next[0];
                        k_reg       <= 4'd1;
                    end
                end
                SEND: begin
                    if (k_reg == 4'd9) begin
                        state_reg <= WAIT;
                        mdsi_reg  <= 1'b0;
                        mdi_reg   <= '0;
                        wcnt_reg  <= '0;
                    end else begin
                        mdi_reg <= win_reg[k_reg];
                        k_reg   <= k_reg + 4'd1;
                    end
                end
                WAIT: begin
                    if (MDSO) begin
                        res_reg     <= MDO;
                        res_vld_reg <= 1'b1;
                        wcnt_reg    <= '0;
                        state_reg   <= IDLE;
                        pix_rdy_reg <= 1'b1;
                    end else if (wcnt_reg == 8'(TMO - 1)) begin
                        // TMO WAIT cycles have elapsed with no answer.
                        err_reg     <= 1'b1;
                        wcnt_reg    <= '0;
                        state_reg   <= IDLE;
                        pix_rdy_reg <= 1'b1;
                    end else begin
                        wcnt_reg <= wcnt_reg + 8'd1;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    pix_rdy_reg <= 1'b0;
                    mdsi_reg    <= 1'b0;
                    mdi_reg     <= '0;
                end
            endcase
        end
    end

    assign PIX_RDY = pix_rdy_reg;
    assign MDI     = mdi_reg;
    assign MDSI    = mdsi_reg;
    assign RES     = res_reg;
    assign RES_VLD = res_vld_reg;
    assign ERR     = err_reg;

endmodule

// File: tb/tb_median_window_feeder.sv
// tb_median_window_feeder
//   Random and directed raster frames drive median_window_feeder (LW=4).
//   The bench also plays the median filter. Expected windows come from a
//   whole-frame pixel array. Expected results come from the responses the
//   bench filter gives.
`timescale 1ns/1ps
module tb_median_window_feeder;
    localparam int W   = 8;
    localparam int LW  = 4;
    localparam int TMO = 255;

    logic         CLK     = 1'b0;
    logic         nRST    = 1'b1;
    logic [W-1:0] PIX_I   = '0;
    logic         PIX_VLD = 1'b0;
    logic         SOF     = 1'b0;
    logic         PIX_RDY;
    logic [W-1:0] MDI;
    logic         MDSI;
    logic [W-1:0] MDO     = '0;
    logic         MDSO    = 1'b0;
    logic [W-1:0] RES;
    logic         RES_VLD;
    logic         ERR;

    always #5 CLK = ~CLK;

    median_window_feeder #(.W(W), .LW(LW), .TMO(TMO)) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .PIX_I   (PIX_I),
        .PIX_VLD (PIX_VLD),
        .SOF     (SOF),
        .PIX_RDY (PIX_RDY),
        .MDI     (MDI),
        .MDSI    (MDSI),
        .MDO     (MDO),
        .MDSO    (MDSO),
        .RES     (RES),
        .RES_VLD (RES_VLD),
        .ERR     (ERR)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: the whole frame as a 2-D pixel array.
    int frame [64][LW];
    int m_row = 0, m_col = 0;
    int exp_mdi[$];     // window pixels still to appear on MDI
    int coll[$];        // window seen by the bench filter
    int mdi_log[$];
    int runs[$];
    int mdsi_run   = 0;
    int wait_cnt   = 0;
    bit mdso_drove = 0;
    int pend_res   = 0;
    int res_exp    = 0;
    bit pend_err   = 0;
    bit err_exp    = 0;
    bit prev_nrst  = 0;
    int resp_delay = 10;   // -1: never answer
    int resp_fixed = -1;   // -1: answer with the true median
    bit rand_delay = 0;
    bit stray_en   = 0;
    int res_cnt    = 0;

    function automatic int median9(input int v[$]);
        int s[$];
        s = v;
        s.sort();
        return s[4];
    endfunction

    task automatic model_accept(input int pix, input bit sof);
        if (sof) begin
            m_row = 0;
            m_col = 0;
        end
        frame[m_row % 64][m_col] = pix;
        if (m_row >= 2 && m_col >= 2) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    exp_mdi.push_back(frame[(m_row - 2 + r) % 64][m_col - 2 + c]);
        end
        m_col++;
        if (m_col == LW) begin
            m_col = 0;
            m_row++;
        end
    endtask

    // Per-cycle monitor and filter, evaluated on the falling edge.
    initial begin
        bit sending, in_wait, vld_now;
        int e;
        forever begin
            @(negedge CLK);
            if (!nRST) begin
                chk("rst_mdsi", MDSI, 0);
                chk("rst_mdi", MDI, 0);
                chk("rst_rdy", PIX_RDY, 0);
                chk("rst_res", RES, 0);
                chk("rst_res_vld", RES_VLD, 0);
                chk("rst_err", ERR, 0);
                exp_mdi.delete();
                coll.delete();
                wait_cnt = 0; mdso_drove = 0; MDSO = 1'b0;
                pend_err = 0; err_exp = 0; res_exp = 0;
                m_row = 0; m_col = 0; prev_nrst = 0; mdsi_run = 0;
                continue;
            end
            sending = (exp_mdi.size() > 0);
            in_wait = !sending && (coll.size() == 9);
            vld_now = mdso_drove;

            if (sending) begin
                e = exp_mdi.pop_front();
                chk("mdsi", MDSI, 1);
                chk("mdi", MDI, e);
                coll.push_back(e);
                mdi_log.push_back(int'(MDI));
            end else begin
                chk("mdsi_low", MDSI, 0);
                chk("mdi_zero", MDI, 0);
            end
            if (MDSI) mdsi_run++;
            else if (mdsi_run > 0) begin
                runs.push_back(mdsi_run);
                mdsi_run = 0;
            end

            chk("res_vld", RES_VLD, vld_now);
            if (vld_now) res_exp = pend_res;
            if (RES_VLD) begin
                res_cnt++;
                $display("result %0d: RES=%0h", res_cnt, RES);
            end
            chk("res", RES, res_exp);
            if (pend_err) begin
                err_exp  = 1;
                pend_err = 0;
            end
            chk("err", ERR, err_exp);
            chk("pix_rdy", PIX_RDY, prev_nrst && !sending && !in_wait);

            MDSO = 1'b0;
            mdso_drove = 0;
            if (in_wait) begin
                wait_cnt++;
                if (wait_cnt == 1 && rand_delay) resp_delay = $urandom_range(0, 60);
                if (resp_delay >= 0 && wait_cnt == resp_delay + 1) begin
                    pend_res = (resp_fixed >= 0) ? resp_fixed : median9(coll);
                    MDO = W'(pend_res);
                    MDSO = 1'b1;
                    mdso_drove = 1;
                    coll.delete();
                    wait_cnt = 0;
                end else if (wait_cnt == TMO) begin
                    pend_err = 1;
                    coll.delete();
                    wait_cnt = 0;
                end
            end else if (stray_en && $urandom_range(0, 5) == 0) begin
                // MDSO outside WAIT must be ignored.
                MDSO = 1'b1;
                MDO  = W'($urandom);
            end
            if (PIX_VLD && PIX_RDY) model_accept(int'(PIX_I), SOF);
            prev_nrst = 1;
        end
    end

    // Drivers. Every task starts and ends 1 ns after a rising edge.
    task automatic send_pix(input int pix, input bit sof, input int gap);
        bit done;
        done = 0;
        PIX_I = W'(pix); SOF = sof; PIX_VLD = 1'b1;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge CLK);
            if (PIX_RDY && nRST) begin
                @(posedge CLK);
                #1;
                done = 1;
            end
        end
        chk("accept_timeout", done, 1);
        PIX_VLD = 1'b0; SOF = 1'b0;
        repeat (gap) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // kind: 0 constant 7, 1 ramp, 2 random
    task automatic send_frame(input int rows, input int kind, input int gapmax, input bit use_sof);
        int pix;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < LW; c++) begin
                pix = (kind == 0) ? 7 : (kind == 1) ? (r * LW + c) : int'($urandom_range(0, 255));
                send_pix(pix, use_sof && r == 0 && c == 0, int'($urandom_range(0, gapmax)));
            end
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(posedge CLK);
            #1;
            if (exp_mdi.size() == 0 && coll.size() == 0 && !mdso_drove && !pend_err) ok = 1;
        end
        chk("idle_timeout", ok, 1);
        repeat (3) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        int base;
        int nruns;
        int ramp_exp[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};

        #1 nRST = 1'b0;
        repeat (3) @(posedge CLK);
        #1 nRST = 1'b1;
        repeat (2) begin
            @(posedge CLK);
            #1;
        end

        // Ramp frame: first window contents and a 9-cycle strobe.
        resp_delay = 10; resp_fixed = -1;
        base = res_cnt; mdi_log.delete(); runs.delete();
        send_frame(3, 1, 0, 1);
        wait_idle();
        chk("ramp_results", res_cnt - base, 2);
        chk("ramp_log_size", mdi_log.size() >= 9, 1);
        if (mdi_log.size() >= 9)
            for (int k = 0; k < 9; k++) chk("ramp_win0", mdi_log[k], ramp_exp[k]);
        chk("ramp_runs", runs.size(), 2);
        if (runs.size() > 0) chk("ramp_run_len", runs[0], 9);

        // Constant 7: two results per line from row 2.
        base = res_cnt;
        send_frame(5, 0, 1, 1);
        wait_idle();
        chk("const_results", res_cnt - base, 6);
        chk("const_res", RES, 7);

        // Late fixed answer 0x5A after 40 WAIT cycles.
        resp_delay = 40; resp_fixed = 8'h5A;
        base = res_cnt;
        send_frame(3, 2, 2, 1);
        wait_idle();
        chk("fixed_results", res_cnt - base, 2);
        chk("fixed_res", RES, 8'h5A);

        // Random pixels, random latency, stray MDSO outside WAIT.
        resp_fixed = -1; rand_delay = 1; stray_en = 1;
        base = res_cnt;
        send_frame(6, 2, 2, 1);
        wait_idle();
        chk("rand_results", res_cnt - base, 8);
        rand_delay = 0; stray_en = 0;

        // SOF reasserted at row 3, col 1.
        resp_delay = 5;
        base = res_cnt; nruns = runs.size();
        send_frame(3, 2, 1, 1);
        send_pix(int'($urandom_range(0, 255)), 0, 0);
        send_frame(3, 2, 1, 1);
        wait_idle();
        chk("sof_results", res_cnt - base, 4);
        chk("sof_sends", runs.size() - nruns, 4);

        // Filter never answers: ERR after TMO WAIT cycles, and ERR stays set.
        resp_delay = -1;
        base = res_cnt;
        send_frame(3, 1, 0, 1);
        wait_idle();
        chk("tmo_err", ERR, 1);
        chk("tmo_results", res_cnt - base, 0);
        resp_delay = 3;
        send_frame(3, 0, 0, 1);
        wait_idle();
        chk("tmo_err_sticky", ERR, 1);
        chk("tmo_after_results", res_cnt - base, 2);

        // Reset during SEND cycle 4 abandons the window.
        resp_delay = 10;
        base = res_cnt;
        for (int c = 0; c < 2 * LW + 3; c++) send_pix(c, c == 0, 0);
        repeat (3) @(posedge CLK);
        #1 nRST = 1'b0;
        #1;
        chk("rst_send_mdsi", MDSI, 0);
        chk("rst_send_mdi", MDI, 0);
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
        repeat (30) begin
            @(posedge CLK);
            #1;
        end
        chk("rst_send_results", res_cnt - base, 0);
        chk("rst_err_clear", ERR, 0);
        base = res_cnt;
        send_frame(3, 2, 1, 0);
        wait_idle();
        chk("post_rst_results", res_cnt - base, 2);

        chk("final_queue", exp_mdi.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/median_window_feeder.md
MEDIAN_WINDOW_FEEDER -- requirements
Module: median_window_feeder

Interface
REQ-001 Parameter W, default 8: pixel width in bits.
REQ-002 Parameter LW, default 16: line width in pixels; legal range 3 to 1024.
REQ-003 Parameter TMO, default 255: maximum WAIT cycles before timeout; legal range 1 to 255.
REQ-004 CLK  input  1  system clock; all logic on the rising edge.
REQ-005 nRST  input  1  asynchronous, active-low reset.
REQ-006 PIX_I  input  W  raster pixel data.
REQ-007 PIX_VLD  input  1  PIX_I valid.
REQ-008 SOF  input  1  start of frame; meaningful only with PIX_VLD=1.
REQ-009 PIX_RDY  output  1  feeder accepts a pixel; a pixel transfers when PIX_VLD=1 and PIX_RDY=1.
REQ-010 MDI  output  W  window pixel to the median filter.
REQ-011 MDSI  output  1  MDI valid strobe to the median filter.
REQ-012 MDO  input  W  median result from the filter.
REQ-013 MDSO  input  1  median result valid.
REQ-014 RES  output  W  registered median result.
REQ-015 RES_VLD  output  1  one-cycle pulse; RES is new.
REQ-016 ERR  output  1  sticky timeout flag.

Function
REQ-017 FSM states: IDLE, SEND, WAIT; all outputs driven from registers.
REQ-018 IDLE: PIX_RDY=1; PIX_RDY=0 in SEND and WAIT.
REQ-019 Accepted pixel with SOF=1: col, row and window start from zero, and this pixel is col 0, row 0.
REQ-020 Accepted pixel at column col: shift the 3x3 window left one column; new right column is {LB1[col], LB0[col], PIX_I}, top to bottom; then LB1[col]<=LB0[col], LB0[col]<=PIX_I.
REQ-021 col increments on each accepted pixel; at LW-1 it wraps to 0 and row increments, saturating at 2.
REQ-022 A window is complete when the accepted pixel has row>=2 and col>=2 (pre-increment values); then go IDLE->SEND next cycle, otherwise stay IDLE.
REQ-023 SEND lasts exactly 9 cycles: MDSI=1, MDI=w[k] for k=0..8, row-major order, top-left first, bottom-right last; then go to WAIT.
REQ-024 WAIT: MDSI=0, MDI=0; wait counter starts at 0 and increments each cycle.
REQ-025 WAIT with MDSO=1: RES<=MDO, RES_VLD=1 for the next cycle only, counter cleared, go to IDLE.
REQ-026 WAIT with counter reaching TMO and MDSO=0: ERR<=1, no RES_VLD, go to IDLE.
REQ-027 ERR is cleared only by reset.
REQ-028 MDSO outside WAIT is ignored; RES and RES_VLD are unchanged.
REQ-029 Line buffers and window are not cleared on SOF; stale contents are never emitted because of REQ-022.
REQ-030 Exactly LW-2 results are produced per line from row 2 onward, in column order.
REQ-031 Latency: first MDSI cycle is the cycle after the completing pixel is accepted; RES_VLD is the cycle after the MDSO cycle.

Reset
REQ-032 nRST=0 forces immediately: state IDLE, PIX_RDY=0 while nRST=0, MDSI=0, MDI=0, RES=0, RES_VLD=0, ERR=0, col=0, row=0, wait counter=0.
REQ-033 Reset mid-SEND or mid-WAIT abandons the window; after release the block behaves as after power-up and requires SOF or 2 full lines to produce a result.
REQ-034 Line buffer RAM contents need not be reset.

Verification
REQ-035 LW=4, frame of constant 7, ideal median model responding 10 cycles after MDSI falls -> RES=7, 2 RES_VLD pulses per line for rows 2..N-1.
REQ-036 LW=4, ramp pixel value = index 0..11 -> first SEND MDI sequence 0,1,2,4,5,6,8,9,10; MDSI high exactly 9 cycles.
REQ-037 Model asserts MDSO with MDO=0x5A after 40 WAIT cycles -> RES=0x5A with one-cycle RES_VLD; PIX_RDY=0 from SEND entry until IDLE.
REQ-038 Model never asserts MDSO, TMO=255 -> ERR=1 after 255 WAIT cycles, no RES_VLD, PIX_RDY=1 next cycle, ERR stays set.
REQ-039 SOF reasserted at row 3, col 1 -> no MDSI until row 2, col 2 of the new frame.
REQ-040 nRST pulsed low during SEND cycle 4 -> MDSI=0 and MDI=0 immediately, RES_VLD never pulses for that window.
